// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
// Holds the FSM state type, the LFSR seed and tap constants, the latency bound,
// the wait-counter width, and the LFSR feedback helper.
package imem_pkg;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Busy    = 2'd1,
    Respond = 2'd2
  } imem_state_e;

  localparam int unsigned LFSR_W      = 8;
  localparam logic [7:0]  LFSR_SEED   = 8'hA5;
  // Taps 8,6,5,4 (1-based), i.e. bits 7,5,4,3.
  localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
  localparam int unsigned MAX_LATENCY = 15;
  // The counter holds MAX_LATENCY plus up to 3 cycles of random stall.
  localparam int unsigned CNT_W       = 5;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/imem_lfsr.sv
// 8-bit Fibonacci LFSR used to add a random stall to the fetch latency.
// Ports: clk, rst (sync, active-high, reloads the seed),
//        step_i (advance one step), state_o (current register value).
module imem_lfsr
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Shift left; the feedback bit enters at the LSB.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_feedback(lfsr_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder.
// It answers single-cycle fetch requests after a programmable latency with a
// one-cycle ready pulse. The backing store is a preloadable word array.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   pc_i, read_instr_i  fetch byte address and request pulse
//   instr_o             returned word (0 on a misaligned fetch)
//   instr_ready_o       one-cycle response pulse
//   instr_err_o         misaligned-fetch flag, valid with instr_ready_o
//   busy_o              high while waiting out the latency
//   proto_err_o         sticky: a request arrived while busy
//   load_en_i, load_addr_i, load_data_i   preload write port
// Optional macro IMEM_RAND_STALL_EN adds 0..3 LFSR-driven stall cycles per
// request.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          pc_i,
  input  logic                           read_instr_i,
  output logic [DATA_WIDTH-1:0]          instr_o,
  output logic                           instr_ready_o,
  output logic                           instr_err_o,
  output logic                           busy_o,
  output logic                           proto_err_o,
  input  logic                           load_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0]          load_data_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  imem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  proto_q, proto_d;

  logic [IDX_W-1:0]      fetch_idx;
  logic                  misalign;
  logic [CNT_W-1:0]      wait_init;
  logic                  unused_pc;

  // Upper address bits are ignored, so the array aliases modulo its depth.
  assign fetch_idx = pc_i[IDX_W+1:2];
  assign misalign  = |pc_i[1:0];
  assign unused_pc = ^pc_i;

`ifdef IMEM_RAND_STALL_EN
  logic [LFSR_W-1:0] lfsr_state;
  logic              lfsr_step_c;
  logic              unused_lfsr;

  // The LFSR advances once per accepted request. Requests are accepted only
  // outside Busy.
  assign lfsr_step_c = read_instr_i && (state_q != Busy);
  assign unused_lfsr = ^lfsr_state[LFSR_W-1:2];

  imem_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step_i  (lfsr_step_c),
    .state_o (lfsr_state)
  );

  assign wait_init = CNT_W'(LATENCY) + CNT_W'(lfsr_state[1:0]);
`else
  assign wait_init = CNT_W'(LATENCY);
`endif

  // Preload port. It is not reset. A fetch accepted at the same edge reads the
  // old word.
  always_ff @(posedge clk) begin
    if (load_en_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    mis_d   = mis_q;
    proto_d = proto_q;

    case (state_q)
      Idle, Respond: begin
        state_d = Idle;
        if (read_instr_i) begin
          // The word is snapshotted at acceptance. A misaligned fetch returns 0.
          word_d  = misalign ? '0 : mem_q[fetch_idx];
          mis_d   = misalign;
          cnt_d   = wait_init;
          state_d = (wait_init == '0) ? Respond : Busy;
        end
      end
      Busy: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = Respond;
        end
        if (read_instr_i) begin
          proto_d = 1'b1;
        end
      end
      default: state_d = Idle;
    endcase

    ready_d = (state_d == Respond);
    busy_d  = (state_d == Busy);
    instr_d = instr_q;
    err_d   = err_q;
    if (state_d == Respond) begin
      instr_d = word_d;
      err_d   = mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Idle;
      cnt_q   <= '0;
      word_q  <= '0;
      mis_q   <= 1'b0;
      instr_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      mis_q   <= mis_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      proto_q <= proto_d;
    end
  end

  assign instr_o       = instr_q;
  assign instr_ready_o = ready_q;
  assign instr_err_o   = err_q;
  assign busy_o        = busy_q;
  assign proto_err_o   = proto_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder.
// Two instances (LATENCY=2 and LATENCY=0) share one stimulus stream. Both are
// checked every cycle against a cycle-accounting reference model.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        read_instr = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  logic [31:0] instr [2];
  logic        ready [2];
  logic        ierr  [2];
  logic        busy  [2];
  logic        proto [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state per instance.
  int          lat   [2] = '{2, 0};
  bit          pend  [2];
  int          acc   [2];
  int          rcy   [2];
  logic [31:0] mword [2];
  bit          merr  [2];
  bit          mproto[2];
  bit          mzero [2];
  logic [31:0] mem_m [1024];

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .pc_i(pc), .read_instr_i(read_instr),
    .instr_o(instr[0]), .instr_ready_o(ready[0]), .instr_err_o(ierr[0]),
    .busy_o(busy[0]), .proto_err_o(proto[0]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  imem_responder #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .pc_i(pc), .read_instr_i(read_instr),
    .instr_o(instr[1]), .instr_ready_o(ready[1]), .instr_err_o(ierr[1]),
    .busy_o(busy[1]), .proto_err_o(proto[1]),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle. Check this cycle's outputs, then drive new inputs and
  // advance the model.
  task automatic step(input bit r_i, input bit rq, input logic [31:0] pc_v,
                      input bit le, input logic [9:0] la, input logic [31:0] ld);
    bit er, eb;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      er = pend[i] && (cyc == rcy[i]);
      eb = pend[i] && (cyc < rcy[i]);
      check($sformatf("ready%0d", i), 32'(ready[i]), 32'(er));
      check($sformatf("busy%0d", i),  32'(busy[i]),  32'(eb));
      check($sformatf("proto%0d", i), 32'(proto[i]), 32'(mproto[i]));
      if (er) begin
        check($sformatf("instr%0d", i), instr[i], merr[i] ? 32'h0 : mword[i]);
        check($sformatf("ierr%0d", i),  32'(ierr[i]), 32'(merr[i]));
      end
      if (mzero[i]) begin
        check($sformatf("rst_instr%0d", i), instr[i], 32'h0);
        check($sformatf("rst_ierr%0d", i),  32'(ierr[i]), 32'h0);
      end
    end
    rst = r_i; read_instr = rq; pc = pc_v;
    load_en = le; load_addr = la; load_data = ld;
    for (int i = 0; i < 2; i++) begin
      if (r_i) begin
        pend[i] = 0; mproto[i] = 0; mzero[i] = 1;
      end else begin
        mzero[i] = 0;
        if (pend[i] && cyc == rcy[i]) pend[i] = 0;
        if (rq) begin
          if (pend[i]) begin
            mproto[i] = 1;
          end else begin
            pend[i]  = 1;
            acc[i]   = cyc;
            rcy[i]   = cyc + 1 + lat[i];
            mword[i] = mem_m[(pc_v >> 2) % 1024];
            merr[i]  = (pc_v % 4) != 0;
          end
        end
      end
    end
    if (le) mem_m[la] = ld;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 10'h0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(0, 1, a, 0, 10'h0, 32'h0);
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    step(0, 0, 32'h0, 1, a, d);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; mproto[i] = 0; mzero[i] = 1;
    end
    step(1, 0, 32'h0, 0, 10'h0, 32'h0);
    step(1, 0, 32'h0, 0, 10'h0, 32'h0);

    // Fill the whole array so that random fetches never read unwritten words.
    for (int a = 0; a < 1024; a++) load(10'(a), $urandom);
    load(10'd0, 32'h00500093);
    load(10'd1, 32'h00100113);
    load(10'd2, 32'h002081B3);
    load(10'd3, 32'h00000013);
    idle();

    // Basic fetch, then a back-to-back request issued in the Respond cycle.
    fetch(32'h0);
    idle();
    check("lat0_rdy", 32'(ready[1]), 32'h1);
    check("lat0_data", instr[1], 32'h00500093);
    idle();
    step(0, 1, 32'h4, 0, 10'h0, 32'h0);
    check("fetch0_rdy", 32'(ready[0]), 32'h1);
    check("fetch0_data", instr[0], 32'h00500093);
    idle(); idle(); idle();
    check("b2b_rdy", 32'(ready[0]), 32'h1);
    check("b2b_data", instr[0], 32'h00100113);
    check("b2b_proto", 32'(proto[0]), 32'h0);
    idle();
    fetch(32'h8);
    idle(); idle(); idle();
    check("fetch8_data", instr[0], 32'h002081B3);
    check("fetch8_err", 32'(ierr[0]), 32'h0);

    // Misaligned fetch.
    fetch(32'h6);
    idle(); idle(); idle();
    check("mis_rdy", 32'(ready[0]), 32'h1);
    check("mis_err", 32'(ierr[0]), 32'h1);
    check("mis_data", instr[0], 32'h0);

    // Wrap with LATENCY=0.
    fetch(32'h1004);
    idle();
    check("wrap_rdy", 32'(ready[1]), 32'h1);
    check("wrap_data", instr[1], 32'h00100113);
    idle(); idle(); idle();

    // A second pulse one cycle after acceptance collides with Busy.
    fetch(32'h8);
    fetch(32'hC);
    idle(); idle(); idle();
    check("coll_one_pulse", 32'(ready[0]), 32'h0);
    check("coll_proto", 32'(proto[0]), 32'h1);
    check("coll_proto_lat0", 32'(proto[1]), 32'h0);

    // Reset in the Busy cycle drops the pending response.
    fetch(32'h0);
    step(1, 0, 32'h0, 0, 10'h0, 32'h0);
    idle();
    check("rstw_proto", 32'(proto[0]), 32'h0);
    check("rstw_rdy", 32'(ready[0]), 32'h0);
    idle();
    check("rstw_no_pulse", 32'(ready[0]), 32'h0);
    fetch(32'h0);
    idle(); idle(); idle();
    check("rstw_retained", instr[0], 32'h00500093);

    // A load and a fetch to the same word at the same edge return the old data.
    step(0, 1, 32'h0, 1, 10'd0, 32'hDEADBEEF);
    idle(); idle(); idle();
    check("same_edge_old", instr[0], 32'h00500093);
    fetch(32'h0);
    idle(); idle(); idle();
    check("same_edge_new", instr[0], 32'hDEADBEEF);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          r, rq, le;
      logic [31:0] a;
      logic [9:0]  la;
      r  = ($urandom_range(0, 149) == 0);
      rq = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 7)) << 2;
      else a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      le = ($urandom_range(0, 3) == 0);
      la = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
      step(r, rq, a, le, la, $urandom);
    end
    idle(); idle(); idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
